// File: rtl/framebuffer_scheduler_if.sv
// Bundles the write-user, framebuffer and engine-output ports of framebuffer_scheduler.
// Every valid/ready pair here transfers on a cycle where both are high; the payload is held while valid && !ready.
interface framebuffer_scheduler_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [9:0]  wr_x;
  logic [9:0]  wr_y;
  logic [31:0] wr_data;

  logic [9:0]  fb_x_pos;
  logic [9:0]  fb_y_pos;
  logic [31:0] fb_data_in;
  logic        fb_read;
  logic        fb_write;
  logic [99:0] fb_data_chunk;
  logic        fb_data_ready;

  logic        out_valid;
  logic        out_ready;
  logic [99:0] out_chunk;
  logic [9:0]  out_x;
  logic [9:0]  out_y;
  logic        out_last;

  modport master (
    input  wr_valid, wr_x, wr_y, wr_data, fb_data_chunk, fb_data_ready, out_ready,
    output wr_ready, fb_x_pos, fb_y_pos, fb_data_in, fb_read, fb_write,
           out_valid, out_chunk, out_x, out_y, out_last
  );

  modport slave (
    output wr_valid, wr_x, wr_y, wr_data, fb_data_chunk, fb_data_ready, out_ready,
    input  wr_ready, fb_x_pos, fb_y_pos, fb_data_in, fb_read, fb_write,
           out_valid, out_chunk, out_x, out_y, out_last
  );
endinterface

// File: rtl/framebuffer_scheduler.sv
// Shares the framebuffer address port between a pixel writer and a raster-scan reader,
// buffering each 5x5 chunk to the convolution engine.
module framebuffer_scheduler #(
  parameter int WIDTH        = 640,
  parameter int HEIGHT       = 480,
  parameter int X_STEP       = 1,
  parameter int WR_BURST_MAX = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int TIMEOUT      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       frame_done,
  output logic       rd_timeout,
  output logic [1:0] dbg_state,
  framebuffer_scheduler_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  localparam int BW = $clog2(WR_BURST_MAX + 2);
  localparam int GW = $clog2(GAP_CYCLES + 2);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [BW-1:0] BURST_MAX = BW'(WR_BURST_MAX);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_CYCLES);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);
  localparam logic [9:0]    LAST_Y    = 10'(HEIGHT - 1);

  state_t        state;
  logic [BW-1:0] burst_cnt;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] wait_cnt;
  logic [9:0]    scan_x;
  logic [9:0]    scan_y;

  logic          rd_eligible;
  logic          grant_rd;
  logic          grant_wr;
  logic [10:0]   x_next;
  logic          row_end;
  logic          last_win;

  // Writes keep priority until WR_BURST_MAX of them have starved an eligible read.
  always_comb begin
    rd_eligible = busy && (gap_cnt == '0) && !bus.out_valid;
    grant_rd    = (state == IDLE) && rd_eligible && (!bus.wr_valid || (burst_cnt == BURST_MAX));
    grant_wr    = (state == IDLE) && bus.wr_valid && !grant_rd;
    x_next      = {1'b0, scan_x} + 11'(X_STEP);
    row_end     = (x_next >= 11'(WIDTH));
    last_win    = row_end && (scan_y == LAST_Y);
  end

  assign bus.wr_ready = grant_wr;
  assign dbg_state    = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      burst_cnt      <= '0;
      gap_cnt        <= '0;
      wait_cnt       <= '0;
      scan_x         <= '0;
      scan_y         <= '0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      rd_timeout     <= 1'b0;
      bus.fb_x_pos   <= '0;
      bus.fb_y_pos   <= '0;
      bus.fb_data_in <= '0;
      bus.fb_read    <= 1'b0;
      bus.fb_write   <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.out_chunk  <= '0;
      bus.out_x      <= '0;
      bus.out_y      <= '0;
      bus.out_last   <= 1'b0;
    end else begin
      bus.fb_write <= 1'b0;
      frame_done   <= 1'b0;

      if (!bus.fb_read && (gap_cnt != '0)) begin
        gap_cnt <= gap_cnt - 1'b1;
      end

      if (start && !busy) begin
        busy       <= 1'b1;
        scan_x     <= '0;
        scan_y     <= '0;
        rd_timeout <= 1'b0;
      end

      if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
        if (bus.out_last) begin
          busy       <= 1'b0;
          frame_done <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (grant_rd) begin
            state     <= RD_REQ;
            burst_cnt <= '0;
          end else if (grant_wr) begin
            bus.fb_write   <= 1'b1;
            bus.fb_x_pos   <= bus.wr_x;
            bus.fb_y_pos   <= bus.wr_y;
            bus.fb_data_in <= bus.wr_data;
            burst_cnt      <= rd_eligible ? burst_cnt + 1'b1 : '0;
          end
        end

        RD_REQ: begin
          bus.fb_read  <= 1'b1;
          bus.fb_x_pos <= scan_x;
          bus.fb_y_pos <= scan_y;
          wait_cnt     <= '0;
          state        <= RD_WAIT;
        end

        RD_WAIT: begin
          // fb_x/y must not move here: the framebuffer output mux follows fb_y_pos.
          if (bus.fb_data_ready || (wait_cnt == WAIT_LAST)) begin
            bus.fb_read <= 1'b0;
            gap_cnt     <= GAP_LOAD;
            state       <= IDLE;
            if (row_end) begin
              scan_x <= '0;
              scan_y <= last_win ? 10'd0 : scan_y + 10'd1;
            end else begin
              scan_x <= x_next[9:0];
            end
            if (bus.fb_data_ready) begin
              bus.out_chunk <= bus.fb_data_chunk;
              bus.out_x     <= bus.fb_x_pos;
              bus.out_y     <= bus.fb_y_pos;
              bus.out_last  <= last_win;
              bus.out_valid <= 1'b1;
            end else begin
              rd_timeout <= 1'b1;
              if (last_win) begin
                busy       <= 1'b0;
                frame_done <= 1'b1;
              end
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_framebuffer_scheduler.sv
// Directed bench for framebuffer_scheduler on a reduced 8x4 frame with a behavioural framebuffer.
module tb_framebuffer_scheduler;
  localparam int W    = 8;
  localparam int H    = 4;
  localparam int GAP  = 2;
  localparam int SB_W = 21;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       busy;
  logic       frame_done;
  logic       rd_timeout;
  logic [1:0] dbg_state;

  framebuffer_scheduler_if bus();

  framebuffer_scheduler #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .frame_done (frame_done),
    .rd_timeout (rd_timeout),
    .dbg_state  (dbg_state),
    .bus        (bus.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [SB_W-1:0] exp_q[$];

  int fb_age, fb_delay, low_cnt, wr_run, reads_in_scan, done_cnt, xfer_cnt;
  logic any_read, drop_en, use_const, wr_mode, gap_exact, ready_prev, pend_wr, found;
  logic [9:0]  rd_x, rd_y, drop_x, drop_y, pend_x, pend_y;
  logic [31:0] pend_d;
  logic [99:0] const_chunk, snap_chunk;
  logic [20:0] snap_meta;

  function automatic logic [99:0] pat(input logic [9:0] x, input logic [9:0] y);
    return {20'hC3C3C, 40'(x), 40'(y)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 128'({busy, frame_done, rd_timeout, bus.fb_read, bus.fb_write, bus.out_valid,
                             bus.out_last, bus.fb_x_pos, bus.fb_y_pos, bus.out_x, bus.out_y, dbg_state}), 128'(0));
    chk({tag, "_chunk"}, 128'(bus.out_chunk), 128'(0));
    chk({tag, "_wdata"}, 128'(bus.fb_data_in), 128'(0));
  endtask

  task automatic fill_exp(input logic den, input int dx, input int dy);
    exp_q.delete();
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (!(den && x == dx && y == dy)) exp_q.push_back({(x == W-1 && y == H-1), 10'(x), 10'(y)});
      end
    end
    xfer_cnt = 0;
    done_cnt = 0;
    reads_in_scan = 0;
  endtask

  // One clock: scoreboard and grant capture before the edge, invariants and framebuffer model after it.
  task automatic tick();
    logic [SB_W-1:0] e;
    logic [99:0] ec;
    @(negedge clk);
    if (bus.out_valid && bus.out_ready) begin
      xfer_cnt++;
      if (exp_q.size() == 0) begin
        chk("sb_extra", 128'({bus.out_x, bus.out_y}), 128'({10'h3FF, 10'h3FF}));
      end else begin
        e  = exp_q.pop_front();
        ec = use_const ? const_chunk : pat(e[19:10], e[9:0]);
        chk("out_x", 128'(bus.out_x), 128'(e[19:10]));
        chk("out_y", 128'(bus.out_y), 128'(e[9:0]));
        chk("out_last", 128'(bus.out_last), 128'(e[20]));
        chk("out_chunk", 128'(bus.out_chunk), 128'(ec));
      end
    end
    pend_wr = bus.wr_ready;
    if (pend_wr) begin
      pend_x = bus.wr_x;
      pend_y = bus.wr_y;
      pend_d = bus.wr_data;
      wr_run++;
    end
    ready_prev = bus.fb_data_ready && reset;
    @(posedge clk);
    #1;
    chk("rd_wr_excl", 128'(bus.fb_read && bus.fb_write), 128'(0));
    chk("fb_write", 128'(bus.fb_write), 128'(pend_wr));
    if (pend_wr) chk("fb_wdata", 128'({bus.fb_x_pos, bus.fb_y_pos, bus.fb_data_in}), 128'({pend_x, pend_y, pend_d}));
    if (ready_prev) chk("lat_valid", 128'(bus.out_valid), 128'(1));
    if (frame_done) done_cnt++;
    if (bus.fb_read) fb_age++;
    else begin
      fb_age = 0;
      low_cnt++;
    end
    if (fb_age == 1) begin
      if (any_read) chk("rd_gap", 128'(low_cnt >= GAP), 128'(1));
      if (gap_exact && reads_in_scan > 0) chk("rd_gap_exact", 128'(low_cnt), 128'(4));
      if (wr_mode && reads_in_scan > 0) chk("wr_burst", 128'(wr_run), 128'(6));
      rd_x = bus.fb_x_pos;
      rd_y = bus.fb_y_pos;
      low_cnt = 0;
      wr_run = 0;
      any_read = 1'b1;
      reads_in_scan++;
    end else if (fb_age > 1) begin
      chk("rd_pos_stable", 128'({bus.fb_x_pos, bus.fb_y_pos}), 128'({rd_x, rd_y}));
    end
    bus.fb_data_ready = bus.fb_read && (fb_age == 2 + fb_delay) && !(drop_en && rd_x == drop_x && rd_y == drop_y);
    bus.fb_data_chunk = !bus.fb_data_ready ? 100'd0 : (use_const ? const_chunk : pat(rd_x, rd_y));
    if (wr_mode) begin
      bus.wr_x    = 10'($urandom_range(0, W-1));
      bus.wr_y    = 10'($urandom_range(0, H-1));
      bus.wr_data = $urandom;
    end
  endtask

  task automatic wait_read_at(input int x, input int y, input string tag);
    found = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (fb_age == 1 && rd_x == 10'(x) && rd_y == 10'(y)) begin
        found = 1'b1;
        break;
      end
    end
    chk(tag, 128'(found), 128'(1));
  endtask

  task automatic wait_next_read(input string tag);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (fb_age == 1) begin
        found = 1'b1;
        break;
      end
    end
    chk(tag, 128'(found), 128'(1));
  endtask

  task automatic wait_done(input string tag);
    found = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (done_cnt > 0) begin
        found = 1'b1;
        break;
      end
    end
    chk(tag, 128'(found), 128'(1));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_x = '0;
    bus.wr_y = '0;
    bus.wr_data = '0;
    bus.fb_data_ready = 1'b0;
    bus.fb_data_chunk = '0;
    bus.out_ready = 1'b0;
    fb_age = 0; fb_delay = 0; low_cnt = 0; wr_run = 0; reads_in_scan = 0; done_cnt = 0; xfer_cnt = 0;
    any_read = 1'b0; drop_en = 1'b0; use_const = 1'b0; wr_mode = 1'b0; gap_exact = 1'b0;
    drop_x = '0; drop_y = '0; rd_x = '0; rd_y = '0;
    const_chunk = {{12{8'hA5}}, 4'hA};

    // Reset values
    repeat (3) tick();
    chk_zero("reset");
    chk("reset_wr_ready", 128'(bus.wr_ready), 128'(0));
    reset = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    chk("idle_busy", 128'(busy), 128'(0));

    // Reset mid-scan abandons the frame
    fill_exp(1'b0, 0, 0);
    pulse_start();
    chk("start_busy", 128'(busy), 128'(1));
    wait_read_at(0, 2, "abort_reach");
    reset = 1'b0;
    bus.fb_data_ready = 1'b0;
    bus.fb_data_chunk = '0;
    fb_age = 0;
    #1;
    chk_zero("abort_async");
    tick();
    chk_zero("abort_held");
    exp_q.delete();
    done_cnt = 0;
    reset = 1'b1;
    repeat (20) tick();
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_no_done", 128'(done_cnt), 128'(0));
    chk("abort_no_valid", 128'(bus.out_valid), 128'(0));

    // Full frame, engine always ready; a second start mid-frame is ignored
    fill_exp(1'b0, 0, 0);
    gap_exact = 1'b1;
    pulse_start();
    repeat (30) tick();
    pulse_start();
    wait_done("frame_end");
    gap_exact = 1'b0;
    chk("frame_busy_clear", 128'(busy), 128'(0));
    repeat (3) tick();
    chk("frame_sb_empty", 128'(exp_q.size()), 128'(0));
    chk("frame_xfers", 128'(xfer_cnt), 128'(W*H));
    chk("frame_done_once", 128'(done_cnt), 128'(1));
    chk("frame_no_timeout", 128'(rd_timeout), 128'(0));

    // Continuous writes: start latches alongside a write grant, then 6 writes per read period
    wr_mode = 1'b1;
    bus.wr_valid = 1'b1;
    tick();
    fill_exp(1'b0, 0, 0);
    pulse_start();
    chk("start_with_wr_busy", 128'(busy), 128'(1));
    chk("start_with_wr_grant", 128'(pend_wr), 128'(1));
    wait_done("wr_frame_end");
    wr_mode = 1'b0;
    bus.wr_valid = 1'b0;
    repeat (3) tick();
    chk("wr_sb_empty", 128'(exp_q.size()), 128'(0));
    chk("wr_done_once", 128'(done_cnt), 128'(1));

    // Engine stalls on chunk (5,0)
    fill_exp(1'b0, 0, 0);
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (bus.out_valid && bus.out_x == 10'd5 && bus.out_y == 10'd0) begin
        found = 1'b1;
        break;
      end
    end
    chk("hold_reach", 128'(found), 128'(1));
    bus.out_ready = 1'b0;
    snap_chunk = bus.out_chunk;
    snap_meta  = {bus.out_last, bus.out_x, bus.out_y};
    chk("hold_chunk_val", 128'(snap_chunk), 128'(pat(10'd5, 10'd0)));
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_valid", 128'(bus.out_valid), 128'(1));
      chk("hold_chunk", 128'(bus.out_chunk), 128'(snap_chunk));
      chk("hold_meta", 128'({bus.out_last, bus.out_x, bus.out_y}), 128'(snap_meta));
      chk("hold_no_read", 128'(bus.fb_read), 128'(0));
    end
    bus.out_ready = 1'b1;
    wait_next_read("hold_next_read");
    chk("hold_next_pos", 128'({rd_x, rd_y}), 128'({10'd6, 10'd0}));
    wait_done("hold_frame_end");
    chk("hold_sb_empty", 128'(exp_q.size()), 128'(0));

    // Framebuffer never answers at (5,2)
    drop_en = 1'b1;
    drop_x = 10'd5;
    drop_y = 10'd2;
    fill_exp(1'b1, 5, 2);
    pulse_start();
    wait_read_at(5, 2, "tmo_reach");
    chk("tmo_state_wait", 128'(dbg_state), 128'(2));
    repeat (7) tick();
    chk("tmo_not_yet", 128'(rd_timeout), 128'(0));
    chk("tmo_still_reading", 128'(bus.fb_read), 128'(1));
    tick();
    chk("tmo_set", 128'(rd_timeout), 128'(1));
    chk("tmo_read_dropped", 128'(bus.fb_read), 128'(0));
    wait_next_read("tmo_next_read");
    chk("tmo_next_pos", 128'({rd_x, rd_y}), 128'({10'd6, 10'd2}));
    wait_done("tmo_frame_end");
    chk("tmo_sticky", 128'(rd_timeout), 128'(1));
    chk("tmo_sb_empty", 128'(exp_q.size()), 128'(0));
    chk("tmo_xfers", 128'(xfer_cnt), 128'(W*H - 1));
    drop_en = 1'b0;

    // Data returned 3 cycles late with a fixed pattern; start clears the sticky timeout
    fb_delay = 3;
    use_const = 1'b1;
    fill_exp(1'b0, 0, 0);
    pulse_start();
    chk("start_clears_tmo", 128'(rd_timeout), 128'(0));
    wait_done("late_frame_end");
    chk("late_sb_empty", 128'(exp_q.size()), 128'(0));
    chk("late_no_timeout", 128'(rd_timeout), 128'(0));
    fb_delay = 0;
    use_const = 1'b0;

    // Last window times out: frame still ends
    drop_en = 1'b1;
    drop_x = 10'(W-1);
    drop_y = 10'(H-1);
    fill_exp(1'b1, W-1, H-1);
    pulse_start();
    wait_done("lasttmo_frame_end");
    chk("lasttmo_busy", 128'(busy), 128'(0));
    chk("lasttmo_flag", 128'(rd_timeout), 128'(1));
    repeat (3) tick();
    chk("lasttmo_done_once", 128'(done_cnt), 128'(1));
    chk("lasttmo_sb_empty", 128'(exp_q.size()), 128'(0));
    drop_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
